instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch-side consumer of the program counter. It takes the current PC and issues word reads to instruction memory over a req/ack handshake. It delivers fetched instructions to decode over a valid/ready handshake, and it returns default_new_pc (PC+4) and a stall indication to the PC-update logic. A jump/flush discards any in-flight or held fetch, so the next instruction comes from the redirected PC.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
RESET_PC, 32'h0000_0000, PC value fetched first after reset
TIMEOUT, 255, max cycles waiting for imem_ack before error (8-bit counter)

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
pc  input  ADDR_W  current PC from PC-update logic
flush  input  1  jump/jal/jr taken this cycle; discard in-flight/held fetch
imem_req  output  1  read request to instruction memory
imem_addr  output  ADDR_W  word-aligned read address ({pc[31:2],2'b00})
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr  output  32  fetched instruction to decode
instr_pc  output  ADDR_W  address instr was fetched from (for jal link / jump base)
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decode accepts instr this cycle
default_new_pc  output  ADDR_W  fetch address + 4, fed back as sequential next PC
stall  output  1  PC must not advance this cycle
fetch_err  output  1  sticky: memory did not ack within TIMEOUT cycles

Behaviour:
- Reset (async, rst=1): state=IDLE; imem_req=0; instr=0; instr_pc=RESET_PC; instr_valid=0; fetch_err=0; timer=0; fetch address register=RESET_PC.
- default_new_pc = fetch address register + 4, combinational; wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- stall = 1 in every state except when a fetch completes and is accepted in the same cycle, or state=IDLE with no held instruction.
- States:
  - IDLE: latch pc into the fetch address register, assert imem_req next cycle; go to REQ.
  - REQ/WAIT: imem_req=1 and imem_addr held stable until imem_ack.
    - imem_ack=1 and flush=0: capture imem_rdata into instr and the fetch address into instr_pc; set instr_valid=1; go to HOLD.
    - Timer increments each cycle without ack. When it reaches TIMEOUT: set fetch_err (sticky until rst), drop imem_req, go to IDLE.
  - HOLD: instr_valid=1 and instr stable until instr_ready=1.
    - instr_ready=1: clear instr_valid next cycle; go to IDLE (new fetch begins following cycle).
    - Latency: pc sampled -> instr_valid minimum 2 cycles with single-cycle ack.
- flush:
  - In REQ/WAIT: keep imem_req until ack (no abort on the bus), then drop the returned data; instr_valid stays 0; go to IDLE.
  - In HOLD: clear instr_valid next cycle without needing instr_ready; go to IDLE.
  - In IDLE: no effect beyond re-latching pc.
- flush and imem_ack in the same cycle: the data is discarded.
- flush and instr_ready in the same cycle in HOLD: treated as flush; decode's accept is ignored.
- imem_ack outside REQ/WAIT is ignored.
- rst mid-fetch: immediate return to reset values; a late imem_ack after reset deassertion is ignored (state=IDLE).
- pc[1:0]≠0: address force-aligned; no error raised.

Decomposition:
- Shared package: state encoding (IDLE, REQ, WAIT, HOLD as 2-bit localparams), RESET_PC default, instruction word width 32.
- One natural sub-module: fetch_timeout_counter (8-bit counter with clear/enable, terminal-count flag). Everything else stays in instr_fetch_unit.

Test Plan:
- Reset release, pc=0, memory acks 1 cycle after req with 32'h2008_0005 -> imem_addr=0; instr=32'h2008_0005, instr_pc=0, instr_valid=1; default_new_pc=4.
- Memory delays ack 3 cycles, pc=32'h40 -> imem_req held high, imem_addr=32'h40 stable 3 cycles; stall=1 throughout; instr valid the cycle after ack.
- instr_ready low 4 cycles in HOLD -> instr/instr_valid stable; stall=1; no new imem_req until the cycle after instr_ready=1.
- flush asserted while waiting on fetch of 32'h100, ack returns 32'hDEAD_BEEF -> instr_valid never rises; next fetch uses the new pc (e.g. 32'h0800_0000).
- No ack for 255 cycles -> fetch_err=1, imem_req=0, state IDLE; fetch_err remains 1 until rst.
- pc=32'hFFFF_FFFC -> default_new_pc=0; rst asserted mid-WAIT then ack arrives -> all outputs at reset values, ack ignored.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit: FSM state encoding,
// reset PC, instruction width and the ack timeout.
package instr_fetch_unit_pkg;

  localparam int          INSTR_W      = 32;
  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          TIMEOUT_DEF  = 255;
  localparam int          TIMER_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_timeout.sv
// Cycle counter for an outstanding memory request; o_tc flags the last
// cycle the fetch may wait for imem_ack before it is abandoned.
module fetch_timeout_counter
  import instr_fetch_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TIMER_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  // Terminal count on the TIMEOUT-th cycle without an ack.
  assign o_tc = (r_count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word reads for the current PC over req/ack and hands
// the instruction to decode over valid/ready; flush discards in-flight work.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                TIMEOUT  = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  default_new_pc,
  output logic               stall,
  output logic               fetch_err
);

  fetch_state_e       r_state, w_next;
  logic [ADDR_W-1:0]  r_fetch_addr;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_valid, r_err, r_drop;

  logic w_latch_pc, w_capture, w_clear_valid, w_set_err;
  logic w_set_drop, w_clr_drop, w_timer_en, w_timer_clr, w_stall, w_tc;
  logic w_unused;

  // Low PC bits are dropped by forced word alignment.
  assign w_unused = ^pc[1:0];

  fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_timer_clr),
    .i_en  (w_timer_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next        = r_state;
    w_latch_pc    = 1'b0;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    w_set_err     = 1'b0;
    w_set_drop    = 1'b0;
    w_clr_drop    = 1'b0;
    w_timer_en    = 1'b0;
    w_timer_clr   = 1'b1;
    w_stall       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_latch_pc = 1'b1;
        w_clr_drop = 1'b1;
        w_stall    = 1'b0;
        w_next     = ST_REQ;
      end
      ST_REQ, ST_WAIT: begin
        if (imem_ack) begin
          // A flush seen now or earlier in this request turns the data into a discard.
          if (flush || r_drop) begin
            w_next = ST_IDLE;
          end else begin
            w_capture = 1'b1;
            w_next    = ST_HOLD;
          end
        end else if (w_tc) begin
          w_set_err = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_timer_clr = 1'b0;
          w_timer_en  = 1'b1;
          w_set_drop  = flush;
          w_next      = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          w_clear_valid = 1'b1;
          w_next        = ST_IDLE;
        end else if (instr_ready) begin
          w_clear_valid = 1'b1;
          w_stall       = 1'b0;
          w_next        = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_addr <= RESET_PC;
      r_instr      <= '0;
      r_instr_pc   <= RESET_PC;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      if (w_latch_pc) r_fetch_addr <= {pc[ADDR_W-1:2], 2'b00};
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_fetch_addr;
        r_valid    <= 1'b1;
      end else if (w_clear_valid) begin
        r_valid <= 1'b0;
      end
      if (w_set_err)       r_err  <= 1'b1;
      if (w_set_drop)      r_drop <= 1'b1;
      else if (w_clr_drop) r_drop <= 1'b0;
    end
  end

  assign imem_req       = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign imem_addr      = r_fetch_addr;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_valid    = r_valid;
  assign default_new_pc = r_fetch_addr + ADDR_W'(4);
  assign stall          = w_stall;
  assign fetch_err      = r_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-computed expectations for fetch
// latency, ack delay, decode backpressure, flush, timeout, PC wrap and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] default_new_pc;
  logic        stall;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .flush          (flush),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .default_new_pc (default_new_pc),
    .stall          (stall),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards take effect at the next edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; pc = 32'h0; flush = 1'b0; imem_ack = 1'b0;
    imem_rdata = 32'h0; instr_ready = 1'b0;
    repeat (2) step();
    settle();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_ipc",   instr_pc, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_err",   32'(fetch_err), 32'd0);
    check("rst_npc",   default_new_pc, 32'h4);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // Single-cycle ack from pc=0.
    step();
    settle();
    check("t1_req",   32'(imem_req), 32'd1);
    check("t1_addr",  imem_addr, 32'h0);
    check("t1_stall", 32'(stall), 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0;
    settle();
    check("t1_valid", 32'(instr_valid), 32'd1);
    check("t1_instr", instr, 32'h2008_0005);
    check("t1_ipc",   instr_pc, 32'h0);
    check("t1_npc",   default_new_pc, 32'h4);
    check("t1_hstall", 32'(stall), 32'd1);
    instr_ready = 1'b1;
    settle();
    check("t1_accept_stall", 32'(stall), 32'd0);
    pc = 32'h40;
    step();
    instr_ready = 1'b0;
    settle();
    check("t1_cleared", 32'(instr_valid), 32'd0);

    // Ack delayed three cycles at pc=0x40.
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t2_req",   32'(imem_req), 32'd1);
      check("t2_addr",  imem_addr, 32'h40);
      check("t2_stall", 32'(stall), 32'd1);
      check("t2_novalid", 32'(instr_valid), 32'd0);
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    settle();
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_instr", instr, 32'h1234_5678);
    check("t2_ipc",   instr_pc, 32'h40);
    check("t2_npc",   default_new_pc, 32'h44);

    // Decode backpressure for four cycles.
    for (int i = 0; i < 4; i++) begin
      check("t3_valid", 32'(instr_valid), 32'd1);
      check("t3_instr", instr, 32'h1234_5678);
      check("t3_stall", 32'(stall), 32'd1);
      check("t3_noreq", 32'(imem_req), 32'd0);
      step();
      settle();
    end
    instr_ready = 1'b1;
    pc = 32'h100;
    step();
    instr_ready = 1'b0;
    settle();
    check("t3_idle_noreq", 32'(imem_req), 32'd0);
    check("t3_idle_valid", 32'(instr_valid), 32'd0);
    step();
    settle();
    check("t3_req",  32'(imem_req), 32'd1);
    check("t3_addr", imem_addr, 32'h100);

    // Flush while waiting on 0x100; the returned word is dropped.
    flush = 1'b1;
    step();
    flush = 1'b0; pc = 32'h0800_0000;
    settle();
    check("t4_req_kept", 32'(imem_req), 32'd1);
    check("t4_addr_kept", imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    settle();
    check("t4_novalid", 32'(instr_valid), 32'd0);
    check("t4_noreq",   32'(imem_req), 32'd0);
    step();
    settle();
    check("t4_newaddr", imem_addr, 32'h0800_0000);
    check("t4_newreq",  32'(imem_req), 32'd1);
    check("t4_novalid2", 32'(instr_valid), 32'd0);

    // Complete that fetch, then flush together with ready in HOLD.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    settle();
    check("t5_valid", 32'(instr_valid), 32'd1);
    check("t5_ipc",   instr_pc, 32'h0800_0000);
    flush = 1'b1; instr_ready = 1'b1;
    settle();
    check("t5_flush_stall", 32'(stall), 32'd1);
    pc = 32'h0000_0207;
    step();
    flush = 1'b0; instr_ready = 1'b0;
    settle();
    check("t5_cleared", 32'(instr_valid), 32'd0);
    // An ack while idle is ignored; unaligned pc is forced to a word address.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    settle();
    check("t6_idle_ack_valid", 32'(instr_valid), 32'd0);
    check("t6_req",   32'(imem_req), 32'd1);
    check("t6_align", imem_addr, 32'h0000_0204);
    check("t6_err",   32'(fetch_err), 32'd0);
    // Flush coinciding with ack: data discarded.
    flush = 1'b1; imem_rdata = 32'hAAAA_AAAA;
    step();
    flush = 1'b0; imem_ack = 1'b0;
    settle();
    check("t6_flushack_valid", 32'(instr_valid), 32'd0);
    check("t6_flushack_instr", instr, 32'h0000_0013);
    pc = 32'h0000_0300;

    // Timeout: 255 cycles of request without ack.
    step();
    settle();
    check("t7_req_start", 32'(imem_req), 32'd1);
    for (int i = 0; i < 254; i++) step();
    settle();
    check("t7_req_last", 32'(imem_req), 32'd1);
    check("t7_err_pre",  32'(fetch_err), 32'd0);
    pc = 32'hFFFF_FFFC;
    step();
    settle();
    check("t7_err",     32'(fetch_err), 32'd1);
    check("t7_req_off", 32'(imem_req), 32'd0);
    check("t7_idle_stall", 32'(stall), 32'd0);

    // Wrap of default_new_pc; fetch_err stays sticky.
    step();
    settle();
    check("t8_addr", imem_addr, 32'hFFFF_FFFC);
    check("t8_npc",  default_new_pc, 32'h0);
    check("t8_err_sticky", 32'(fetch_err), 32'd1);
    step();
    settle();
    check("t8_wait_req", 32'(imem_req), 32'd1);

    // Reset mid-wait, then a late ack.
    rst = 1'b1;
    settle();
    check("t9_req",   32'(imem_req), 32'd0);
    check("t9_err",   32'(fetch_err), 32'd0);
    check("t9_valid", 32'(instr_valid), 32'd0);
    check("t9_instr", instr, 32'h0);
    check("t9_ipc",   instr_pc, 32'h0);
    check("t9_npc",   default_new_pc, 32'h4);
    step();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    step();
    settle();
    check("t9_late_valid", 32'(instr_valid), 32'd0);
    check("t9_late_req",   32'(imem_req), 32'd1);
    check("t9_late_instr", instr, 32'h0);
    imem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
